// File: rtl/player_jump_ctrl_if.sv
// Frame/button/pause inputs and motion outputs of the player jump controller.
interface player_jump_ctrl_if;
    logic       frame_tick;
    logic       jump_btn;
    logic       pause;
    logic [9:0] y_pos;
    logic       airborne;
    logic       landed;

    modport master (
        output frame_tick, jump_btn, pause,
        input  y_pos, airborne, landed
    );

    modport slave (
        input  frame_tick, jump_btn, pause,
        output y_pos, airborne, landed
    );
endinterface

// File: rtl/player_jump_ctrl.sv
// Frame-locked vertical motion of the player sprite: jump on a synchronised button
// edge, integer gravity, ceiling clamp and landing pulse.
module player_jump_ctrl #(
    parameter int unsigned GROUND_Y = 400,
    parameter int unsigned CEIL_Y   = 40,
    parameter int unsigned JUMP_VEL = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 12
) (
    input logic                clk,
    input logic                rst_n,
    player_jump_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
    localparam logic signed [10:0] CEIL_S   = 11'(CEIL_Y);
    localparam logic signed [10:0] JUMP_S   = 11'(JUMP_VEL);
    localparam logic [5:0]         JUMP_V6  = 6'(JUMP_VEL);
    localparam logic [5:0]         GRAV6    = 6'(GRAVITY);
    localparam logic [5:0]         MAXF6    = 6'(MAX_FALL);

    state_t             state, state_nxt;
    logic               sync1, sync2, prev;
    logic               jump_pending;
    logic               rise_edge, tick_ok;
    logic [9:0]         y_q, y_nxt;
    logic [5:0]         speed, speed_nxt;
    logic               landed_q, landed_nxt;
    logic               airborne_q;
    logic signed [10:0] y_s, t;
    logic [6:0]         fall_sum;

    assign rise_edge = sync2 & ~prev;
    assign tick_ok   = bus.frame_tick & ~bus.pause;
    assign y_s       = signed'({1'b0, y_q});

    always_comb begin
        state_nxt  = state;
        y_nxt      = y_q;
        speed_nxt  = speed;
        landed_nxt = 1'b0;
        t          = '0;
        fall_sum   = '0;
        if (tick_ok) begin
            case (state)
                GROUNDED: begin
                    if (jump_pending) begin
                        y_nxt     = 10'(GROUND_S - JUMP_S);
                        speed_nxt = JUMP_V6 - GRAV6;
                        state_nxt = RISING;
                    end
                end
                RISING: begin
                    t = y_s - signed'({5'b0, speed});
                    if (t <= CEIL_S) begin
                        y_nxt     = 10'(CEIL_S);
                        speed_nxt = '0;
                        state_nxt = FALLING;
                    end else begin
                        y_nxt = 10'(t);
                        if (speed <= GRAV6) begin
                            speed_nxt = '0;
                            state_nxt = FALLING;
                        end else begin
                            speed_nxt = speed - GRAV6;
                        end
                    end
                end
                FALLING: begin
                    t = y_s + signed'({5'b0, speed});
                    if (t >= GROUND_S) begin
                        y_nxt      = 10'(GROUND_S);
                        speed_nxt  = '0;
                        state_nxt  = GROUNDED;
                        landed_nxt = 1'b1;
                    end else begin
                        y_nxt     = 10'(t);
                        fall_sum  = {1'b0, speed} + {1'b0, GRAV6};
                        speed_nxt = (fall_sum > {1'b0, MAXF6}) ? MAXF6 : fall_sum[5:0];
                    end
                end
                default: state_nxt = GROUNDED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            prev         <= 1'b0;
            jump_pending <= 1'b0;
            state        <= GROUNDED;
            y_q          <= 10'(GROUND_Y);
            speed        <= '0;
            landed_q     <= 1'b0;
            airborne_q   <= 1'b0;
        end else begin
            sync1 <= bus.jump_btn;
            sync2 <= sync1;
            prev  <= sync2;
            // A consumed tick clears pending, but an edge arriving on that same tick survives.
            if (tick_ok)
                jump_pending <= rise_edge;
            else if (rise_edge)
                jump_pending <= 1'b1;
            state      <= state_nxt;
            y_q        <= y_nxt;
            speed      <= speed_nxt;
            landed_q   <= landed_nxt;
            airborne_q <= (state_nxt != GROUNDED);
        end
    end

    assign bus.y_pos    = y_q;
    assign bus.airborne = airborne_q;
    assign bus.landed   = landed_q;
endmodule

// File: tb/tb_player_jump_ctrl.sv
// Directed scenarios plus randomized stimulus against a signed-velocity reference model.
module tb_player_jump_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   landed_cnt = 0;

    always #5 clk = ~clk;

    player_jump_ctrl_if bus ();
    player_jump_ctrl_if bus2 ();

    player_jump_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    player_jump_ctrl #(.CEIL_Y(340), .JUMP_VEL(40)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    localparam int G = 400, C = 40, J = 12, GR = 1, MF = 12;

    // Reference model: position plus signed velocity (negative = upward).
    int m_y, m_v;
    bit m_up, m_air, m_pend, m_land;
    bit h1, h2, h3;
    int traj [0:25];

    task automatic model_reset();
        m_y = G; m_v = 0; m_up = 0; m_air = 0; m_pend = 0; m_land = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_edge(input bit b, input bit tk, input bit p);
        bit rise;
        int t;
        rise   = h2 & ~h3;  // button level seen two edges ago, not three
        m_land = 0;
        if (tk && !p) begin
            if (!m_air) begin
                if (m_pend) begin
                    m_y = G - J; m_v = -(J - GR); m_up = 1; m_air = 1;
                end
            end else if (m_up) begin
                t = m_y + m_v;
                if (t <= C) begin
                    m_y = C; m_v = 0; m_up = 0;
                end else begin
                    m_y = t;
                    if (-m_v <= GR) begin m_v = 0; m_up = 0; end
                    else m_v = m_v + GR;
                end
            end else begin
                t = m_y + m_v;
                if (t >= G) begin
                    m_y = G; m_v = 0; m_air = 0; m_land = 1;
                end else begin
                    m_y = t;
                    m_v = (m_v + GR > MF) ? MF : m_v + GR;
                end
            end
            m_pend = rise;
        end else if (rise) begin
            m_pend = 1;
        end
        h3 = h2; h2 = h1; h1 = b;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit b, input bit tk, input bit p);
        bus.jump_btn = b; bus.frame_tick = tk; bus.pause = p;
        @(posedge clk);
        model_edge(b, tk, p);
        @(negedge clk);
        if (bus.landed === 1'b1) landed_cnt++;
        chk("y_pos", 16'(bus.y_pos), 16'(m_y));
        chk("airborne", 16'(bus.airborne), 16'(m_air));
        chk("landed", 16'(bus.landed), 16'(m_land));
    endtask

    task automatic tick();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
    endtask

    task automatic press();
        repeat (3) cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_y", 16'(bus.y_pos), 16'd400);
        chk("rst_air", 16'(bus.airborne), 16'd0);
        chk("rst_landed", 16'(bus.landed), 16'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.jump_btn = 0; bus.frame_tick = 0; bus.pause = 0;
        bus2.jump_btn = 0; bus2.frame_tick = 0; bus2.pause = 0;
        model_reset();
        @(negedge clk);
        async_reset();
        repeat (2) cycle(0, 0, 0);

        // Full arc
        press();
        traj[0] = G;
        landed_cnt = 0;
        for (int k = 1; k <= 25; k++) begin
            cycle(0, 1, 0);
            traj[k] = m_y;
            if (k == 1)  chk("arc_t1", 16'(bus.y_pos), 16'd388);
            if (k == 12) chk("arc_apex", 16'(bus.y_pos), 16'd322);
            if (k == 13) chk("arc_t13", 16'(bus.y_pos), 16'd322);
            if (k == 25) begin
                chk("arc_land_y", 16'(bus.y_pos), 16'd400);
                chk("arc_land_pulse", 16'(bus.landed), 16'd1);
                chk("arc_land_air", 16'(bus.airborne), 16'd0);
            end
            repeat (2) cycle(0, 0, 0);
        end
        chk("landed_count", 16'(landed_cnt), 16'd1);

        // Reset mid-arc, then no motion without a press
        press();
        repeat (6) tick();
        chk("pre_reset_air", 16'(bus.airborne), 16'd1);
        async_reset();
        repeat (4) tick();
        chk("post_reset_y", 16'(bus.y_pos), 16'd400);

        // Press while airborne is discarded
        press();
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) begin
                cycle(1, 1, 0);
                repeat (2) cycle(1, 0, 0);
                cycle(0, 0, 0);
            end else begin
                tick();
            end
            if (k == 5) ; else chk("air_press_traj", 16'(bus.y_pos), 16'(traj[k]));
        end
        repeat (3) tick();
        chk("air_press_y", 16'(bus.y_pos), 16'd400);
        chk("air_press_ground", 16'(bus.airborne), 16'd0);

        // Pause freezes motion and pending; resumes seamlessly
        press();
        for (int k = 1; k <= 5; k++) tick();
        for (int i = 0; i < 10; i++) begin
            cycle((i >= 3 && i < 6), 1, 1);
            chk("pause_frozen", 16'(bus.y_pos), 16'(traj[5]));
        end
        repeat (4) cycle(0, 0, 1);
        for (int k = 6; k <= 25; k++) begin
            tick();
            chk("pause_resume", 16'(bus.y_pos), 16'(traj[k]));
        end
        repeat (3) tick();
        chk("pause_press_dropped", 16'(bus.airborne), 16'd0);

        // Edge coincides with tick while grounded
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        chk("coinc_no_move", 16'(bus.y_pos), 16'd400);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("coinc_jump", 16'(bus.y_pos), 16'd388);
        async_reset();

        // Ceiling clamp on the alternate instance
        bus2.jump_btn = 1;
        repeat (3) cycle(0, 0, 0);
        bus2.jump_btn = 0;
        repeat (2) cycle(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            bus2.frame_tick = 1;
            cycle(0, 0, 0);
            bus2.frame_tick = 0;
            cycle(0, 0, 0);
            case (k)
                1: chk("ceil_t1", 16'(bus2.y_pos), 16'd360);
                2: chk("ceil_clamp", 16'(bus2.y_pos), 16'd340);
                3: chk("ceil_hold", 16'(bus2.y_pos), 16'd340);
                default: chk("ceil_fall", 16'(bus2.y_pos), 16'd341);
            endcase
        end
        async_reset();

        // Randomized stimulus
        begin
            bit b = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) b = ~b;
                if ($urandom_range(0, 599) == 0) begin
                    async_reset();
                end
                cycle(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
                checks++;
                assert (bus.y_pos >= 10'(C) && bus.y_pos <= 10'(G)) else begin
                    errors++;
                    $error("FAIL y_range observed=%0d expected=%0d..%0d", bus.y_pos, C, G);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
